// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Modulo-n increment of a requester index.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after start_i, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int unsigned   j;
   logic [IW-1:0] jw;

   // Walk the requests from start_i and take the first one found.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 32'd0;
      jw      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(start_i) + k;
         if (j >= N) j = j - N;
         jw = IW'(j);
         if (!any_o && req_i[jw]) begin
            any_o       = 1'b1;
            grant_o[jw] = 1'b1;
            idx_o       = jw;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with burst lock on req_last. Optional per-requester beat counters are
// built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_write_en,
   output logic [DATA_WIDTH-1:0]         fifo_d_in,
   input  logic                          fifo_full,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          locked
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic                          stat_clr,
   output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_beats
`endif
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] prio_q, prio_d;
   logic [IW-1:0] owner_q, owner_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic [IW-1:0]      win_idx;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i   (req_valid),
      .start_i (prio_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // State, priority pointer and burst owner registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         prio_q  <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
      end
   end

   // Next-state and zero-latency handshake outputs; full or reset freezes everything.
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      owner_d   = owner_q;
      req_ready = '0;
      win_idx   = '0;
      if (!reset && !fifo_full) begin
         unique case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  req_ready = pick_grant;
                  win_idx   = pick_idx;
                  if (req_last[pick_idx]) begin
                     prio_d = IW'(rr_next(32'(pick_idx), NUM_REQ));
                  end else begin
                     state_d = ARB_LOCKED;
                     owner_d = pick_idx;
                  end
               end
            end
            ARB_LOCKED: begin
               if (req_valid[owner_q]) begin
                  req_ready[owner_q] = 1'b1;
                  win_idx            = owner_q;
                  if (req_last[owner_q]) begin
                     state_d = ARB_IDLE;
                     prio_d  = IW'(rr_next(32'(owner_q), NUM_REQ));
                  end
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   // Data mux toward the FIFO; zero when nothing is written.
   always_comb begin
      fifo_write_en = |req_ready;
      grant_id      = win_idx;
      fifo_d_in     = '0;
      if (fifo_write_en) fifo_d_in = req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
   end

   assign locked = (state_q == ARB_LOCKED);

`ifdef FIFO_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

   // Saturating accept counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || stat_clr) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_beats[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 requesters, 8-bit data).
module tb_fifo_wr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 8;
`ifdef FIFO_ARB_STATS_EN
   localparam int unsigned CW = 4;
`else
   localparam int unsigned CW = 16;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid, req_last, req_ready;
   logic [NR*DW-1:0] req_data;
   logic             fifo_write_en, fifo_full, locked;
   logic [DW-1:0]    fifo_d_in;
   logic [1:0]       grant_id;
`ifdef FIFO_ARB_STATS_EN
   logic             stat_clr;
   logic [NR*CW-1:0] stat_beats;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_write_en (fifo_write_en),
      .fifo_d_in     (fifo_d_in),
      .fifo_full     (fifo_full),
      .grant_id      (grant_id),
      .locked        (locked)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_beats    (stat_beats)
`endif
   );

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic [3:0] l;
      logic       f;
      logic [3:0] rdy;
      logic [1:0] gid;
      logic       lk;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] l, input logic f,
                      input logic [3:0] rdy, input logic [1:0] gid, input logic lk);
      vec_t t;
      t.rst = rst; t.v = v; t.l = l; t.f = f; t.rdy = rdy; t.gid = gid; t.lk = lk;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_d;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      reset     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
      stat_clr  = 1'b0;
`endif

      //   rst  valid    last     full  ready    gid  locked
      // reset held with everyone valid
      add(1, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 0);
      // single-beat round robin 0,1,2,3,0
      add(0, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 0);
      add(0, 4'b1111, 4'b1111, 0, 4'b0010, 2'd1, 0);
      add(0, 4'b1111, 4'b1111, 0, 4'b0100, 2'd2, 0);
      add(0, 4'b1111, 4'b1111, 0, 4'b1000, 2'd3, 0);
      add(0, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 0);
      // full stalls 3 cycles, pointer held at 1
      add(0, 4'b0010, 4'b0010, 1, 4'b0000, 2'd0, 0);
      add(0, 4'b0010, 4'b0010, 1, 4'b0000, 2'd0, 0);
      add(0, 4'b1011, 4'b1011, 1, 4'b0000, 2'd0, 0);
      add(0, 4'b1011, 4'b1011, 0, 4'b0010, 2'd1, 0);
      // req2 burst of 3 with a bubble, req0/1 valid throughout
      add(0, 4'b0111, 4'b0011, 0, 4'b0100, 2'd2, 0);
      add(0, 4'b0111, 4'b0011, 0, 4'b0100, 2'd2, 1);
      add(0, 4'b0011, 4'b0011, 0, 4'b0000, 2'd0, 1);
      add(0, 4'b0111, 4'b0111, 0, 4'b0100, 2'd2, 1);
      add(0, 4'b0011, 4'b0011, 0, 4'b0001, 2'd0, 0);
      // nothing valid
      add(0, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
      // req3 mid-burst then reset pulse
      add(0, 4'b1000, 4'b0000, 0, 4'b1000, 2'd3, 0);
      add(0, 4'b1000, 4'b0000, 0, 4'b1000, 2'd3, 1);
      add(1, 4'b1111, 4'b1111, 0, 4'b0000, 2'd0, 1);
      add(0, 4'b1111, 4'b1111, 0, 4'b0001, 2'd0, 0);
      add(0, 4'b1111, 4'b1111, 0, 4'b0010, 2'd1, 0);
      // full during a lock; other requesters stay blocked
      add(0, 4'b0001, 4'b0000, 0, 4'b0001, 2'd0, 0);
      add(0, 4'b0001, 4'b0000, 1, 4'b0000, 2'd0, 1);
      add(0, 4'b0011, 4'b0001, 0, 4'b0001, 2'd0, 1);
      add(0, 4'b0011, 4'b0011, 0, 4'b0010, 2'd1, 0);

      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         req_valid = vecs[i].v;
         req_last  = vecs[i].l;
         fifo_full = vecs[i].f;
         #1;
         exp_d = (vecs[i].rdy != 4'b0000) ? 8'hA0 + 8'(vecs[i].gid) : 8'h00;
         chk("req_ready",     i, 32'(req_ready),     32'(vecs[i].rdy));
         chk("fifo_write_en", i, 32'(fifo_write_en), 32'(vecs[i].rdy != 4'b0000));
         chk("grant_id",      i, 32'(grant_id),      32'(vecs[i].gid));
         chk("fifo_d_in",     i, 32'(fifo_d_in),     32'(exp_d));
         chk("locked",        i, 32'(locked),        32'(vecs[i].lk));
      end

`ifdef FIFO_ARB_STATS_EN
      @(negedge clk);
      reset = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1 chk("stat_reset", 100, 32'(stat_beats), 32'd0);
      req_valid = 4'b0010; req_last = 4'b0010;
      repeat (5) @(negedge clk);
      #1 chk("stat_5beats", 101, 32'(stat_beats[1*CW +: CW]), 32'd5);
      chk("stat_others", 102, 32'(stat_beats), 32'h0000_0050);
      repeat (15) @(negedge clk);
      #1 chk("stat_saturate", 103, 32'(stat_beats[1*CW +: CW]), 32'd15);
      req_valid = '0;
      stat_clr  = 1'b1;
      @(negedge clk);
      #1 chk("stat_clr", 104, 32'(stat_beats), 32'd0);
      req_valid = 4'b0010;
      @(negedge clk);
      #1 chk("stat_clr_vs_accept", 105, 32'(stat_beats), 32'd0);
      stat_clr = 1'b0;
      @(negedge clk);
      #1 chk("stat_after_clr", 106, 32'(stat_beats[1*CW +: CW]), 32'd1);
      req_valid = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
